// File: rtl/moving_avg_filter_if.sv
// rtl/moving_avg_filter_if.sv - sample stream, window select and averaged output bundle
interface moving_avg_filter_if #(
    parameter int DW = 16
);
    logic                 sample_in;
    logic signed [DW-1:0] data_in;
    logic [1:0]           win_sel;
    logic                 flush;
    logic signed [DW-1:0] data_out;
    logic                 valid_out;
    logic                 full_out;

    modport master (
        output sample_in, data_in, win_sel, flush,
        input  data_out, valid_out, full_out
    );

    modport slave (
        input  sample_in, data_in, win_sel, flush,
        output data_out, valid_out, full_out
    );
endinterface

// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - circular-buffer moving average, window 2/4/8/16 taps
// Optional MAF_ROUND_EN: round half up instead of floor truncation on the output divide.
module moving_avg_filter #(
    parameter int DW       = 16,
    parameter int MAX_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    moving_avg_filter_if.slave bus
);
    localparam int DEPTH = 1 << MAX_LOG2;
    localparam int AW    = DW + MAX_LOG2;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t                state, state_nxt;
    logic [1:0]            win_q, n_sel;
    logic signed [DW-1:0]  hist [DEPTH];
    logic signed [AW-1:0]  acc, acc_new, acc_rnd;
    logic signed [DW-1:0]  avg;
    logic [MAX_LOG2-1:0]   wr_ptr, rd_idx;
    logic [MAX_LOG2:0]     fill_cnt, fill_nxt, n_taps;
    logic [2:0]            lg;
    logic                  clear, accept;

    assign lg     = {1'b0, n_sel} + 3'd1;
    assign n_taps = (MAX_LOG2 + 1)'(1) << lg;
    // For N = DEPTH the oldest entry sits at wr_ptr itself and is read before overwrite.
    assign rd_idx = wr_ptr - n_taps[MAX_LOG2-1:0];

    // A sample arriving while win_sel disagrees with the active window is dropped,
    // covering the change cycle itself before the registered copy triggers the clear.
    assign clear  = bus.flush || (win_q != n_sel);
    assign accept = bus.sample_in && !clear && (bus.win_sel == n_sel);

    assign acc_new = acc + {{MAX_LOG2{bus.data_in[DW-1]}}, bus.data_in}
                         - {{MAX_LOG2{hist[rd_idx][DW-1]}}, hist[rd_idx]};
`ifdef MAF_ROUND_EN
    assign acc_rnd = acc_new + (AW'(1) << (lg - 3'd1));
`else
    assign acc_rnd = acc_new;
`endif
    assign avg = DW'(acc_rnd >>> lg);

    assign bus.full_out = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        if (clear) begin
            state_nxt = EMPTY;
            fill_nxt  = '0;
        end else if (accept) begin
            if (fill_cnt != n_taps)
                fill_nxt = fill_cnt + 1'b1;
            state_nxt = (fill_nxt == n_taps) ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                hist[i] <= '0;
            acc           <= '0;
            wr_ptr        <= '0;
            win_q         <= 2'b00;
            n_sel         <= 2'b00;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            win_q         <= bus.win_sel;
            bus.valid_out <= accept;
            if (clear) begin
                for (int i = 0; i < DEPTH; i++)
                    hist[i] <= '0;
                acc    <= '0;
                wr_ptr <= '0;
                n_sel  <= win_q;
            end else if (accept) begin
                hist[wr_ptr] <= bus.data_in;
                acc          <= acc_new;
                wr_ptr       <= wr_ptr + 1'b1;
                bus.data_out <= avg;
            end
        end
    end
endmodule

// File: tb/tb_moving_avg_filter.sv
// tb/tb_moving_avg_filter.sv - directed vector table plus multi-cycle sequences for moving_avg_filter
module tb_moving_avg_filter;
    logic clk;
    logic rst_n;

    moving_avg_filter_if #(.DW(16)) bus ();

    moving_avg_filter #(.DW(16), .MAX_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int win;
        int smp;
        int fl;
        int din;
        int ev;
        int eo;
        int ef;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

`ifdef MAF_ROUND_EN
    localparam int R_P3 = 2;
    localparam int R_M3 = -1;
    localparam int R_S2 = -28672;
`else
    localparam int R_P3 = 1;
    localparam int R_M3 = -2;
    localparam int R_S2 = -28673;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.sample_in = 1'b0;
        bus.flush     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic strobe(input int d);
        bus.data_in   = 16'(d);
        bus.sample_in = 1'b1;
        tick();
        bus.sample_in = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int ev, input int eo, input int ef);
        chk({nm, ".valid"}, int'(bus.valid_out), ev);
        chk({nm, ".data"},  int'(bus.data_out),  eo);
        chk({nm, ".full"},  int'(bus.full_out),  ef);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.sample_in = 1'b0;
        bus.data_in   = '0;
        bus.win_sel   = 2'b01;
        bus.flush     = 1'b0;

        // Scenario 1 (N=4, strobe every 3 cycles) and scenario 3 (N=2 rounding)
        vq.push_back('{1, 1, 0, 1000, 1, 250, 0});
        vq.push_back('{1, 0, 0, 0,    0, 250, 0});
        vq.push_back('{1, 0, 0, 0,    0, 250, 0});
        vq.push_back('{1, 1, 0, 1000, 1, 500, 0});
        vq.push_back('{1, 0, 0, 0,    0, 500, 0});
        vq.push_back('{1, 0, 0, 0,    0, 500, 0});
        vq.push_back('{1, 1, 0, 1000, 1, 750, 0});
        vq.push_back('{1, 0, 0, 0,    0, 750, 0});
        vq.push_back('{1, 0, 0, 0,    0, 750, 0});
        vq.push_back('{1, 1, 0, 1000, 1, 1000, 1});
        vq.push_back('{1, 0, 0, 0,    0, 1000, 1});
        vq.push_back('{1, 0, 0, 0,    0, 1000, 1});
        vq.push_back('{1, 1, 0, 1000, 1, 1000, 1});
        vq.push_back('{1, 0, 0, 0,    0, 1000, 1});
        vq.push_back('{0, 0, 0, 0,    0, 1000, 1});
        vq.push_back('{0, 0, 0, 0,    0, 1000, 0});
        vq.push_back('{0, 1, 0, 0,    1, 0, 0});
        vq.push_back('{0, 1, 0, 3,    1, R_P3, 1});
        vq.push_back('{0, 0, 1, 0,    0, R_P3, 0});
        vq.push_back('{0, 1, 0, 0,    1, 0, 0});
        vq.push_back('{0, 1, 0, -3,   1, R_M3, 1});
        vq.push_back('{0, 0, 0, 0,    0, R_M3, 1});

        #12;
        chk_out("reset", 0, 0, 0);
        #1 rst_n = 1'b1;
        idle(3);
        chk_out("post_clear", 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.win_sel   = 2'(vq[i].win);
            bus.sample_in = 1'(vq[i].smp);
            bus.flush     = 1'(vq[i].fl);
            bus.data_in   = 16'(vq[i].din);
            tick();
            chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].eo, vq[i].ef);
        end
        idle(1);

        // Scenario 2: N=16, extreme values back to back
        bus.win_sel = 2'b11;
        idle(3);
        bus.sample_in = 1'b1;
        bus.data_in   = -16'sd32768;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s2.neg_valid", int'(bus.valid_out), 1);
            if (i == 0)  chk("s2.neg_first", int'(bus.data_out), -2048);
            if (i == 14) chk("s2.full15", int'(bus.full_out), 0);
            if (i == 15) chk("s2.full16", int'(bus.full_out), 1);
        end
        chk("s2.neg_settle", int'(bus.data_out), -32768);
        bus.data_in = 16'sd32767;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s2.pos_valid", int'(bus.valid_out), 1);
            if (i == 0) chk("s2.pos_first", int'(bus.data_out), R_S2);
        end
        chk_out("s2.pos_settle", 1, 32767, 1);
        idle(1);
        chk("s2.valid_drop", int'(bus.valid_out), 0);

        // Scenario 4: N=8 full, flush collides with a sample
        bus.win_sel = 2'b10;
        idle(3);
        for (int i = 0; i < 8; i++) strobe(400);
        chk_out("s4.full", 1, 400, 1);
        bus.flush     = 1'b1;
        bus.sample_in = 1'b1;
        bus.data_in   = 16'sd9999;
        tick();
        bus.flush     = 1'b0;
        bus.sample_in = 1'b0;
        chk_out("s4.flush", 0, 400, 0);
        strobe(800);
        chk_out("s4.after", 1, 100, 0);
        idle(1);

        // Scenario 5: N=4 full, window widened to 16 with a colliding sample
        bus.win_sel = 2'b01;
        idle(3);
        for (int i = 0; i < 4; i++) strobe(1000);
        chk_out("s5.full", 1, 1000, 1);
        bus.win_sel   = 2'b11;
        bus.data_in   = 16'sd5000;
        bus.sample_in = 1'b1;
        tick();
        bus.sample_in = 1'b0;
        chk("s5.discard", int'(bus.valid_out), 0);
        tick();
        chk_out("s5.clear", 0, 1000, 0);
        strobe(1600);
        chk_out("s5.first", 1, 100, 0);
        for (int i = 1; i < 15; i++) strobe(1600);
        chk_out("s5.fifteen", 1, 1500, 0);
        strobe(1600);
        chk_out("s5.sixteen", 1, 1600, 1);
        idle(1);

        // Scenario 6: asynchronous reset mid-fill
        bus.win_sel = 2'b00;
        idle(3);
        strobe(100);
        chk_out("s6.pre", 1, 50, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_out("s6.in_reset", 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        strobe(10);
        chk_out("s6.first", 1, 5, 0);
        strobe(20);
        chk_out("s6.second", 1, 15, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/moving_avg_filter.md
MOVING_AVG_FILTER -- requirements
Module: moving_avg_filter

Interface
REQ-001 Parameter DW, default 16: sample width, signed two's complement.
REQ-002 Parameter MAX_LOG2, default 4: log2 of the maximum window depth (16 taps).
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 sample_in  input  1: one-cycle strobe; data_in is valid this cycle.
REQ-006 data_in  input  DW: signed sample from the waveform generator (wave_out).
REQ-007 win_sel  input  2: window depth N; 00=2, 01=4, 10=8, 11=16.
REQ-008 flush  input  1: synchronous clear of the history buffer and accumulator.
REQ-009 data_out  output  DW: signed moving average.
REQ-010 valid_out  output  1: one-cycle pulse; data_out updated this cycle.
REQ-011 full_out  output  1: high once N samples have entered the window since the last clear.

Function
REQ-012 The history SHALL be a 2^MAX_LOG2-entry circular buffer with a write pointer that wraps from 15 to 0.
REQ-013 On an accepted sample, the block SHALL write data_in at wr_ptr and set acc <= acc + data_in - buf[(wr_ptr - N) mod 16].
REQ-014 acc SHALL be signed DW+MAX_LOG2 bits (20), and it SHALL never overflow.
REQ-015 data_out SHALL equal (acc_new) >>> log2(N), arithmetic shift, registered.
REQ-016 valid_out SHALL pulse exactly one cycle after each accepted sample_in (latency 1); back-to-back strobes SHALL give back-to-back pulses.
REQ-017 Cleared buffer entries SHALL read as zero, so the output during fill is sum/N with zero padding.
REQ-018 FSM states SHALL be EMPTY, FILLING and FULL.
- EMPTY -> FILLING on the first accepted sample.
- FILLING -> FULL when fill_cnt reaches N.
- any state -> EMPTY on a clear.
REQ-019 fill_cnt SHALL saturate at N; full_out SHALL be high exactly in FULL.
REQ-020 A clear SHALL zero all buffer entries, acc, wr_ptr and fill_cnt in one cycle; data_out SHALL hold its last value.
REQ-021 flush SHALL cause a clear.
REQ-022 win_sel SHALL be registered each cycle; when the registered value differs from the active N, the block SHALL clear and adopt the new N.
REQ-023 flush and sample_in in the same cycle: the clear SHALL win, the sample SHALL be discarded, and no valid_out SHALL follow.
REQ-024 A win_sel change and sample_in in the same cycle: the clear SHALL win and the sample SHALL be discarded.
REQ-025 Without sample_in, all state and outputs SHALL hold (valid_out low).

Reset
REQ-026 While rst_n is low, the block SHALL asynchronously set: buffer=0, acc=0, wr_ptr=0, fill_cnt=0, state=EMPTY, data_out=0, valid_out=0, full_out=0, registered win_sel=00 (N=2).
REQ-027 Reset asserted mid-fill or mid-run SHALL discard all history; the first sample after release SHALL be treated as sample 1.

Configuration
REQ-028 With macro MAF_ROUND_EN defined, data_out SHALL be (acc + 2^(log2(N)-1)) >>> log2(N) (round half up); the result SHALL not exceed 32767 for DW=16.
REQ-029 Without MAF_ROUND_EN, data_out SHALL be acc >>> log2(N) (floor truncation).
REQ-030 The macro SHALL not change latency, ports or FSM behaviour.

Verification
REQ-031 Scenario 1: N=4, constant 1000 strobed every 3 cycles.
- Outputs SHALL be 250, 500, 750, 1000, 1000.
- full_out SHALL rise with the 4th valid_out.
- Each valid_out SHALL come 1 cycle after its strobe.
REQ-032 Scenario 2: N=16, 20 samples of -32768, then 20 samples of +32767, back-to-back.
- Output SHALL settle at -32768, then at 32767.
- acc SHALL show no wrap; wr_ptr SHALL wrap cleanly.
REQ-033 Scenario 3: N=2, inputs 0 then 3.
- Output SHALL be 2 with MAF_ROUND_EN and 1 without.
- Inputs 0 then -3 SHALL give -1 with MAF_ROUND_EN and -2 without.
REQ-034 Scenario 4: N=8 in FULL, then flush and sample_in in the same cycle.
- No valid_out; state SHALL be EMPTY; full_out SHALL drop.
- The next sample of 800 SHALL give output 100.
REQ-035 Scenario 5: N=4 in FULL at 1000, then win_sel changes to 16.
- The block SHALL clear; the next sample of 1600 SHALL give output 100; full_out SHALL be low until 16 samples.
REQ-036 Scenario 6: rst_n pulsed low asynchronously (not clock-aligned) mid-fill.
- All outputs SHALL be 0 immediately.
- After release with N=2, sample 10 SHALL give output 5.
